pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Drives the enable/flush controls of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write-enable of the 5-stage MIPS datapath.
- Resolves four hazard classes: data-memory wait, taken branch, load-use and ID-stage jump. It also handles instruction-fetch miss and halt drain.
- Holds an FSM, a data-wait watchdog and saturating performance counters.

Parameters:
- CNT_W, 32, width of performance counters.
- DWAIT_MAX, 1024, consecutive data-wait cycles before `dwait_err` is set.

Ports:
- CLK in 1: clock, rising edge.
- RST in 1: synchronous reset, active-high.
- ihit in 1: instruction fetch completed this cycle.
- dhit in 1: data access completed this cycle.
- mem_req in 1: EX/MEM register holds a load or store (MEM_dREN|MEM_dWEN).
- idex_dREN in 1: ID/EX register holds a load.
- idex_rt in 5: destination of that load.
- ifid_rs in 5: first source of the IF/ID instruction.
- ifid_rt in 5: second source of the IF/ID instruction.
- ifid_uses_rt in 1: IF/ID instruction reads rt.
- branch_taken in 1: EX/MEM holds a resolved taken branch or JR.
- jump_id in 1: IF/ID holds J/JAL.
- halt_mem in 1: EX/MEM holds HALT.
- pc_en out 1: PC loads next PC.
- IF_EN, ID_EN, EX_EN, MEM_EN out 1 each: register enables.
- IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH out 1 each: clear register to bubble on next edge.
- halted out 1: core halted.
- dwait_err out 1: sticky watchdog error.
- cycle_cnt, stall_cnt, flush_cnt out CNT_W each: performance counters.

Behaviour:
- FLUSH has priority over EN in every pipeline register; this block may assert both.
- FSM states: RUN, DWAIT, DRAIN, HALTED. Reset state is RUN.
- Reset values: all counters 0, dwait_err 0, halted 0, every EN 0, every FLUSH 0. Outputs are combinational from state and inputs, so they show RUN evaluation on the first cycle after reset.
- RUN evaluation, first match wins:
  1. dstall = mem_req & !dhit: pc_en=IF_EN=ID_EN=EX_EN=MEM_EN=0, MEM_FLUSH=1, other flushes 0. Next state DWAIT.
  2. halt_mem: MEM_EN=1, IF_FLUSH=ID_FLUSH=EX_FLUSH=1, pc_en=0. Next state DRAIN.
  3. branch_taken: pc_en=1, all EN=1, IF_FLUSH=ID_FLUSH=EX_FLUSH=1. Applies regardless of ihit.
  4. loaduse: idex_dREN & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)). Then pc_en=0, IF_EN=0, ID_FLUSH=1, EX_EN=MEM_EN=1.
  5. jump_id: pc_en=1, IF_FLUSH=1, other EN=1.
  6. !ihit: pc_en=0, IF_FLUSH=1, ID_EN=EX_EN=MEM_EN=1.
  7. Otherwise all EN=1, pc_en=1, all FLUSH=0.
- DWAIT:
  - While !dhit, outputs equal case 1.
  - On dhit, outputs equal RUN evaluation with dstall forced 0, and next state is the matching RUN successor (RUN or DRAIN).
  - Wait counter is cleared on entry and increments each DWAIT cycle, saturating. When it reaches DWAIT_MAX, dwait_err is set and stays set until RST.
  - The FSM does not leave DWAIT on error.
- DRAIN (one cycle): all EN=0, MEM_FLUSH=0, pc_en=0. The halt now sits in MEM/WB. Next state HALTED.
- HALTED: all EN=0, all FLUSH=0, pc_en=0, halted=1. Ignores every input until RST.
- Counters:
  - cycle_cnt increments every non-reset cycle, including HALTED.
  - stall_cnt increments when pc_en=0 and state!=HALTED.
  - flush_cnt increments when IF_FLUSH=1 due to case 3 or 5 only.
  - All counters saturate at all-ones.
- A branch that arrives during dstall is not lost: EX/MEM is frozen, so branch_taken persists and is served on the dhit cycle.
- RST mid-DWAIT or in HALTED: next cycle RUN with counters and dwait_err cleared.

Test Plan:
- Straight-line code, ihit=1 every cycle, no hazards, 10 cycles: all EN=1, pc_en=1, flushes 0; cycle_cnt=10, stall_cnt=0.
- Load into rt=5 in ID/EX with ifid_rs=5: one cycle of pc_en=0, IF_EN=0, ID_FLUSH=1. Same case with idex_rt=0: no stall. stall_cnt=1.
- mem_req=1 with dhit low for 3 cycles, then high: 3 cycles of all EN=0 and MEM_FLUSH=1, FSM in DWAIT. On the dhit cycle all EN=1. stall_cnt=3.
- branch_taken together with ihit=0: pc_en=1, IF/ID/EX flush, flush_cnt=1. Branch held during a 2-cycle dstall is served only on the dhit cycle.
- halt_mem=1: flush cycle, then DRAIN, then halted=1 on the third cycle with all EN=0. Pulsing RST returns to RUN with all counters 0.
- DWAIT_MAX=4 and dhit held low for 6 cycles: dwait_err rises after the 4th wait cycle and remains 1 after dhit.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall controller for a 5-stage MIPS pipeline. It drives the
// enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers,
// plus the PC write-enable. A small FSM (RUN / DWAIT / DRAIN / HALTED)
// sequences data-memory waits and the halt drain. A watchdog flags data
// waits that last too long, and three saturating counters track cycles,
// stalls and control-flow flushes.
//
// Ports:
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   ihit, dhit      instruction / data access completed this cycle
//   mem_req         EX/MEM holds a load or store
//   idex_dREN       ID/EX holds a load; idex_rt is its destination
//   ifid_rs/rt      sources of the IF/ID instruction; ifid_uses_rt if rt read
//   branch_taken    EX/MEM holds a resolved taken branch or JR
//   jump_id         IF/ID holds J/JAL
//   halt_mem        EX/MEM holds HALT
//   pc_en           PC loads next PC
//   *_EN / *_FLUSH  per-register enable / clear-to-bubble (FLUSH wins)
//   halted          core halted
//   dwait_err       sticky data-wait watchdog error
//   cycle_cnt, stall_cnt, flush_cnt   saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int CNT_W     = 32,
   parameter int DWAIT_MAX = 1024
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_req,
   input  logic             idex_dREN,
   input  logic [4:0]       idex_rt,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             branch_taken,
   input  logic             jump_id,
   input  logic             halt_mem,
   output logic             pc_en,
   output logic             IF_EN,
   output logic             ID_EN,
   output logic             EX_EN,
   output logic             MEM_EN,
   output logic             IF_FLUSH,
   output logic             ID_FLUSH,
   output logic             EX_FLUSH,
   output logic             MEM_FLUSH,
   output logic             halted,
   output logic             dwait_err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {ST_RUN, ST_DWAIT, ST_DRAIN, ST_HALTED} state_t;

   localparam int            WW   = $clog2(DWAIT_MAX + 1);
   localparam logic [WW-1:0] WMAX = WW'(DWAIT_MAX);

   state_t             state_q, state_d;
   logic [WW-1:0]      wcnt_q, wcnt_d;
   logic               dwait_err_q, dwait_err_d;
   logic [CNT_W-1:0]   cycle_q, cycle_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic [CNT_W-1:0]   flush_q, flush_d;

   logic dstall;
   logic loaduse;
   logic hold_mem;   // data access still outstanding in the current state
   logic flush_evt;  // IF flush caused by a taken branch or an ID jump

   assign dstall  = mem_req & ~dhit;
   assign loaduse = idex_dREN && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

   // In DWAIT the access is already known to be pending, so only dhit matters;
   // once dhit arrives the normal RUN priority chain takes over.
   assign hold_mem = (state_q == ST_RUN) ? dstall : ~dhit;

   always_comb begin
      state_d   = state_q;
      flush_evt = 1'b0;
      pc_en     = 1'b0;
      IF_EN     = 1'b0;
      ID_EN     = 1'b0;
      EX_EN     = 1'b0;
      MEM_EN    = 1'b0;
      IF_FLUSH  = 1'b0;
      ID_FLUSH  = 1'b0;
      EX_FLUSH  = 1'b0;
      MEM_FLUSH = 1'b0;
      halted    = 1'b0;

      case (state_q)
         ST_RUN, ST_DWAIT: begin
            if (hold_mem) begin
               // Freeze everything; the bubble into MEM/WB keeps the
               // waiting access from retiring twice.
               MEM_FLUSH = 1'b1;
               state_d   = ST_DWAIT;
            end else if (halt_mem) begin
               MEM_EN   = 1'b1;
               IF_FLUSH = 1'b1;
               ID_FLUSH = 1'b1;
               EX_FLUSH = 1'b1;
               state_d  = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
               if (branch_taken) begin
                  pc_en     = 1'b1;
                  IF_EN     = 1'b1;
                  ID_EN     = 1'b1;
                  EX_EN     = 1'b1;
                  MEM_EN    = 1'b1;
                  IF_FLUSH  = 1'b1;
                  ID_FLUSH  = 1'b1;
                  EX_FLUSH  = 1'b1;
                  flush_evt = 1'b1;
               end else if (loaduse) begin
                  // Hold PC and IF/ID, insert a bubble into ID/EX.
                  ID_EN    = 1'b1;
                  EX_EN    = 1'b1;
                  MEM_EN   = 1'b1;
                  ID_FLUSH = 1'b1;
               end else if (jump_id) begin
                  pc_en     = 1'b1;
                  IF_EN     = 1'b1;
                  ID_EN     = 1'b1;
                  EX_EN     = 1'b1;
                  MEM_EN    = 1'b1;
                  IF_FLUSH  = 1'b1;
                  flush_evt = 1'b1;
               end else if (!ihit) begin
                  ID_EN    = 1'b1;
                  EX_EN    = 1'b1;
                  MEM_EN   = 1'b1;
                  IF_FLUSH = 1'b1;
               end else begin
                  pc_en  = 1'b1;
                  IF_EN  = 1'b1;
                  ID_EN  = 1'b1;
                  EX_EN  = 1'b1;
                  MEM_EN = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_HALTED;
         end
         ST_HALTED: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Controls read as idle while reset is held.
      if (RST) begin
         pc_en     = 1'b0;
         IF_EN     = 1'b0;
         ID_EN     = 1'b0;
         EX_EN     = 1'b0;
         MEM_EN    = 1'b0;
         IF_FLUSH  = 1'b0;
         ID_FLUSH  = 1'b0;
         EX_FLUSH  = 1'b0;
         MEM_FLUSH = 1'b0;
         halted    = 1'b0;
         flush_evt = 1'b0;
      end

      // Data-wait watchdog: restarts on DWAIT entry, counts DWAIT cycles.
      wcnt_d      = wcnt_q;
      dwait_err_d = dwait_err_q;
      if ((state_q == ST_RUN) && dstall) begin
         wcnt_d = '0;
      end else if (state_q == ST_DWAIT) begin
         if (wcnt_q != WMAX) begin
            wcnt_d = wcnt_q + WW'(1);
         end
         if (wcnt_d == WMAX) begin
            dwait_err_d = 1'b1;
         end
      end

      cycle_d = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
      stall_d = (!pc_en && (state_q != ST_HALTED) && !(&stall_q)) ?
                stall_q + CNT_W'(1) : stall_q;
      flush_d = (flush_evt && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_RUN;
         wcnt_q      <= '0;
         dwait_err_q <= 1'b0;
         cycle_q     <= '0;
         stall_q     <= '0;
         flush_q     <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         dwait_err_q <= dwait_err_d;
         cycle_q     <= cycle_d;
         stall_q     <= stall_d;
         flush_q     <= flush_d;
      end
   end

   assign dwait_err = dwait_err_q;
   assign cycle_cnt = cycle_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for pipeline_hazard_ctrl. Inputs change 1 ns after the
// rising edge; combinational controls are sampled 1 ns later, counters right
// after the edge that updates them. The control outputs are packed as
// {pc_en, IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 8;

   // Expected control patterns and care-masks (bit 6 = ID_EN, bit 7 = IF_EN).
   localparam logic [8:0] E_IDLE   = 9'b0_0000_0000;
   localparam logic [8:0] E_NORMAL = 9'b1_1111_0000;
   localparam logic [8:0] E_DSTALL = 9'b0_0000_0001;
   localparam logic [8:0] E_HALTFL = 9'b0_0001_1110;
   localparam logic [8:0] E_BRANCH = 9'b1_1111_1110;
   localparam logic [8:0] E_LDUSE  = 9'b0_0011_0100;
   localparam logic [8:0] M_LDUSE  = 9'b1_1011_1111;
   localparam logic [8:0] E_JUMP   = 9'b1_1111_1000;
   localparam logic [8:0] E_IMISS  = 9'b0_0111_1000;
   localparam logic [8:0] M_IMISS  = 9'b1_0111_1111;
   localparam logic [8:0] M_DRAIN  = 9'b1_1111_0001;

   logic             CLK = 1'b0;
   logic             RST;
   logic             ihit, dhit, mem_req, idex_dREN, ifid_uses_rt;
   logic [4:0]       idex_rt, ifid_rs, ifid_rt;
   logic             branch_taken, jump_id, halt_mem;
   logic             pc_en, IF_EN, ID_EN, EX_EN, MEM_EN;
   logic             IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH;
   logic             halted, dwait_err;
   logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
   logic [8:0]       ctl;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   assign ctl = {pc_en, IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH};

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DWAIT_MAX(4)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
      .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs),
      .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .branch_taken(branch_taken), .jump_id(jump_id), .halt_mem(halt_mem),
      .pc_en(pc_en), .IF_EN(IF_EN), .ID_EN(ID_EN), .EX_EN(EX_EN), .MEM_EN(MEM_EN),
      .IF_FLUSH(IF_FLUSH), .ID_FLUSH(ID_FLUSH), .EX_FLUSH(EX_FLUSH), .MEM_FLUSH(MEM_FLUSH),
      .halted(halted), .dwait_err(dwait_err),
      .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; idex_dREN = 1'b0;
      idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
      branch_taken = 1'b0; jump_id = 1'b0; halt_mem = 1'b0;
   endtask

   // Leaves the bench 1 ns after an edge with RST just released.
   task automatic do_reset();
      RST = 1'b1;
      idle_inputs();
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      idle_inputs();
      tick();
      tick();
      n_chk++;
      if (ctl !== E_IDLE || halted !== 1'b0 || dwait_err !== 1'b0) begin
         $display("FAIL reset_ctl: ctl=%b halted=%b err=%b, need ctl=%b halted=0 err=0",
                  ctl, halted, dwait_err, E_IDLE);
         n_fail++;
      end
      n_chk++;
      if (cycle_cnt !== 8'd0 || stall_cnt !== 8'd0 || flush_cnt !== 8'd0) begin
         $display("FAIL reset_cnt: cyc=%0d stall=%0d flush=%0d, need 0/0/0",
                  cycle_cnt, stall_cnt, flush_cnt);
         n_fail++;
      end
      RST = 1'b0;
      #1;
      n_chk++;
      if (ctl !== E_NORMAL) begin
         $display("FAIL reset_first_run: ctl=%b need %b", ctl, E_NORMAL);
         n_fail++;
      end
      $display("test_reset done");
   endtask

   task automatic test_straight_line();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         #1;
         n_chk++;
         if (ctl !== E_NORMAL) begin
            $display("FAIL straight_c%0d: ctl=%b need %b", c, ctl, E_NORMAL);
            n_fail++;
         end
         tick();
      end
      n_chk++;
      if (cycle_cnt !== 8'd10 || stall_cnt !== 8'd0 || flush_cnt !== 8'd0) begin
         $display("FAIL straight_cnt: cyc=%0d stall=%0d flush=%0d, need 10/0/0",
                  cycle_cnt, stall_cnt, flush_cnt);
         n_fail++;
      end
      $display("test_straight_line done");
   endtask

   task automatic test_loaduse();
      do_reset();
      // rs match
      idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7; ifid_uses_rt = 1'b0;
      #1;
      n_chk++;
      if ((ctl & M_LDUSE) !== E_LDUSE) begin
         $display("FAIL loaduse_rs: ctl=%b need %b (mask %b)", ctl, E_LDUSE, M_LDUSE);
         n_fail++;
      end
      tick();
      idex_dREN = 1'b0;
      #1;
      n_chk++;
      if (ctl !== E_NORMAL) begin
         $display("FAIL loaduse_after: ctl=%b need %b", ctl, E_NORMAL);
         n_fail++;
      end
      tick();
      // load to $zero never stalls
      idex_dREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
      #1;
      n_chk++;
      if (ctl !== E_NORMAL) begin
         $display("FAIL loaduse_r0: ctl=%b need %b", ctl, E_NORMAL);
         n_fail++;
      end
      tick();
      // rt match only counts when rt is read
      idex_rt = 5'd9; ifid_rs = 5'd1; ifid_rt = 5'd9; ifid_uses_rt = 1'b1;
      #1;
      n_chk++;
      if ((ctl & M_LDUSE) !== E_LDUSE) begin
         $display("FAIL loaduse_rt: ctl=%b need %b (mask %b)", ctl, E_LDUSE, M_LDUSE);
         n_fail++;
      end
      tick();
      ifid_uses_rt = 1'b0;
      #1;
      n_chk++;
      if (ctl !== E_NORMAL) begin
         $display("FAIL loaduse_rt_unused: ctl=%b need %b", ctl, E_NORMAL);
         n_fail++;
      end
      tick();
      n_chk++;
      if (stall_cnt !== 8'd2 || cycle_cnt !== 8'd5) begin
         $display("FAIL loaduse_cnt: stall=%0d cyc=%0d, need 2/5", stall_cnt, cycle_cnt);
         n_fail++;
      end
      idle_inputs();
      $display("test_loaduse done");
   endtask

   task automatic test_dwait();
      do_reset();
      mem_req = 1'b1; dhit = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_chk++;
         if (ctl !== E_DSTALL) begin
            $display("FAIL dwait_c%0d: ctl=%b need %b", c, ctl, E_DSTALL);
            n_fail++;
         end
         tick();
      end
      dhit = 1'b1;
      #1;
      n_chk++;
      if (ctl !== E_NORMAL) begin
         $display("FAIL dwait_hit: ctl=%b need %b", ctl, E_NORMAL);
         n_fail++;
      end
      tick();
      // dhit low without a request must not look like a wait any more
      mem_req = 1'b0; dhit = 1'b0;
      #1;
      n_chk++;
      if (ctl !== E_NORMAL) begin
         $display("FAIL dwait_exit: ctl=%b need %b", ctl, E_NORMAL);
         n_fail++;
      end
      tick();
      n_chk++;
      if (stall_cnt !== 8'd3 || cycle_cnt !== 8'd5 || dwait_err !== 1'b0) begin
         $display("FAIL dwait_cnt: stall=%0d cyc=%0d err=%b, need 3/5/0",
                  stall_cnt, cycle_cnt, dwait_err);
         n_fail++;
      end
      $display("test_dwait done");
   endtask

   task automatic test_branch_jump();
      do_reset();
      ihit = 1'b0; branch_taken = 1'b1;
      #1;
      n_chk++;
      if (ctl !== E_BRANCH) begin
         $display("FAIL branch_imiss: ctl=%b need %b", ctl, E_BRANCH);
         n_fail++;
      end
      tick();
      ihit = 1'b1; branch_taken = 1'b0;
      tick();
      n_chk++;
      if (flush_cnt !== 8'd1 || stall_cnt !== 8'd0) begin
         $display("FAIL branch_cnt: flush=%0d stall=%0d, need 1/0", flush_cnt, stall_cnt);
         n_fail++;
      end
      // branch waiting behind a 2-cycle data stall
      mem_req = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_chk++;
         if (ctl !== E_DSTALL) begin
            $display("FAIL branch_held_c%0d: ctl=%b need %b", c, ctl, E_DSTALL);
            n_fail++;
         end
         tick();
      end
      dhit = 1'b1;
      #1;
      n_chk++;
      if (ctl !== E_BRANCH) begin
         $display("FAIL branch_on_dhit: ctl=%b need %b", ctl, E_BRANCH);
         n_fail++;
      end
      tick();
      mem_req = 1'b0; dhit = 1'b0; branch_taken = 1'b0;
      // branch beats a simultaneous load-use
      idex_dREN = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3; branch_taken = 1'b1;
      #1;
      n_chk++;
      if (ctl !== E_BRANCH) begin
         $display("FAIL branch_over_loaduse: ctl=%b need %b", ctl, E_BRANCH);
         n_fail++;
      end
      tick();
      idex_dREN = 1'b0; branch_taken = 1'b0;
      jump_id = 1'b1;
      #1;
      n_chk++;
      if (ctl !== E_JUMP) begin
         $display("FAIL jump_id: ctl=%b need %b", ctl, E_JUMP);
         n_fail++;
      end
      tick();
      jump_id = 1'b0; ihit = 1'b0;
      #1;
      n_chk++;
      if ((ctl & M_IMISS) !== E_IMISS) begin
         $display("FAIL imiss: ctl=%b need %b (mask %b)", ctl, E_IMISS, M_IMISS);
         n_fail++;
      end
      tick();
      ihit = 1'b1;
      n_chk++;
      if (flush_cnt !== 8'd4 || stall_cnt !== 8'd3) begin
         $display("FAIL branch_jump_cnt: flush=%0d stall=%0d, need 4/3", flush_cnt, stall_cnt);
         n_fail++;
      end
      $display("test_branch_jump done");
   endtask

   task automatic test_halt();
      do_reset();
      halt_mem = 1'b1; branch_taken = 1'b1;
      #1;
      n_chk++;
      if (ctl !== E_HALTFL || halted !== 1'b0) begin
         $display("FAIL halt_flush: ctl=%b halted=%b need %b/0", ctl, halted, E_HALTFL);
         n_fail++;
      end
      tick();
      halt_mem = 1'b0;
      #1;
      n_chk++;
      if ((ctl & M_DRAIN) !== E_IDLE || halted !== 1'b0) begin
         $display("FAIL halt_drain: ctl=%b halted=%b need %b/0 (mask %b)",
                  ctl, halted, E_IDLE, M_DRAIN);
         n_fail++;
      end
      tick();
      #1;
      n_chk++;
      if (ctl !== E_IDLE || halted !== 1'b1) begin
         $display("FAIL halt_halted: ctl=%b halted=%b need %b/1", ctl, halted, E_IDLE);
         n_fail++;
      end
      tick();
      n_chk++;
      if (cycle_cnt !== 8'd3 || stall_cnt !== 8'd2 || flush_cnt !== 8'd0) begin
         $display("FAIL halt_cnt: cyc=%0d stall=%0d flush=%0d, need 3/2/0",
                  cycle_cnt, stall_cnt, flush_cnt);
         n_fail++;
      end
      // sit halted long enough for the cycle counter to saturate
      for (int c = 0; c < 260; c++) tick();
      n_chk++;
      if (cycle_cnt !== 8'hFF || stall_cnt !== 8'd2 || halted !== 1'b1) begin
         $display("FAIL halt_saturate: cyc=%0d stall=%0d halted=%b, need 255/2/1",
                  cycle_cnt, stall_cnt, halted);
         n_fail++;
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      branch_taken = 1'b0;
      #1;
      n_chk++;
      if (ctl !== E_NORMAL || halted !== 1'b0 || cycle_cnt !== 8'd0 || stall_cnt !== 8'd0) begin
         $display("FAIL halt_reset: ctl=%b halted=%b cyc=%0d stall=%0d, need %b/0/0/0",
                  ctl, halted, cycle_cnt, stall_cnt, E_NORMAL);
         n_fail++;
      end
      $display("test_halt done");
   endtask

   task automatic test_watchdog();
      do_reset();
      mem_req = 1'b1; dhit = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         #1;
         n_chk++;
         if (ctl !== E_DSTALL) begin
            $display("FAIL wdog_ctl_c%0d: ctl=%b need %b", c, ctl, E_DSTALL);
            n_fail++;
         end
         if (c == 5) begin
            n_chk++;
            if (dwait_err !== 1'b0) begin
               $display("FAIL wdog_early: err=%b need 0", dwait_err);
               n_fail++;
            end
         end
         if (c == 6) begin
            n_chk++;
            if (dwait_err !== 1'b1) begin
               $display("FAIL wdog_set: err=%b need 1", dwait_err);
               n_fail++;
            end
         end
         tick();
      end
      dhit = 1'b1;
      #1;
      n_chk++;
      if (ctl !== E_NORMAL || dwait_err !== 1'b1) begin
         $display("FAIL wdog_dhit: ctl=%b err=%b need %b/1", ctl, dwait_err, E_NORMAL);
         n_fail++;
      end
      tick();
      mem_req = 1'b0; dhit = 1'b0;
      tick();
      n_chk++;
      if (dwait_err !== 1'b1) begin
         $display("FAIL wdog_sticky: err=%b need 1", dwait_err);
         n_fail++;
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      n_chk++;
      if (dwait_err !== 1'b0 || ctl !== E_NORMAL) begin
         $display("FAIL wdog_reset: err=%b ctl=%b need 0/%b", dwait_err, ctl, E_NORMAL);
         n_fail++;
      end
      $display("test_watchdog done");
   endtask

   initial begin
      test_reset();
      test_straight_line();
      test_loaduse();
      test_dwait();
      test_branch_jump();
      test_halt();
      test_watchdog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
